rect_layer_ctrl: RTL

RECT_LAYER_CTRL -- requirements
Module: rect_layer_ctrl

---
 rtl/rect_layer_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rect_layer_ctrl.sv
// Four-rectangle overlay with double-buffered descriptors: writes land in a
// shadow set that is copied to the displayed set on the next v_sync falling edge.
module rect_layer_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_clk,
  input  logic [9:0] pix_x,
  input  logic [8:0] pix_y,
  input  logic       v_sync,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_addr,
  input  logic [9:0] wr_data,
  input  logic       commit_req,
  output logic       commit_done,
  output logic       r_out,
  output logic       g_out,
  output logic       b_out
);

  // state      | meaning
  // ST_IDLE    | accepting writes, waiting for commit_req
  // ST_PENDING | writes stalled, waiting for v_sync falling edge
  // ST_COMMIT  | one clk: shadow set copied to active set
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  logic [1:0] state, state_nxt;
  logic       vs_prev;
  logic       vs_fall;
  logic       wr_fire;
  logic [1:0] wr_idx;
  logic [2:0] wr_field;

  logic [9:0] sh_x0 [4];
  logic [9:0] sh_x1 [4];
  logic [8:0] sh_y0 [4];
  logic [8:0] sh_y1 [4];
  logic [3:0] sh_ctrl [4];
  logic [9:0] act_x0 [4];
  logic [9:0] act_x1 [4];
  logic [8:0] act_y0 [4];
  logic [8:0] act_y1 [4];
  logic [3:0] act_ctrl [4];

  logic [2:0] hit_rgb;

  assign vs_fall     = vs_prev & ~v_sync;
  assign wr_ready    = (state == ST_IDLE);
  assign commit_done = (state == ST_COMMIT);
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_idx      = wr_addr[4:3];
  assign wr_field    = wr_addr[2:0];

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:    state_nxt = commit_req ? ST_PENDING : ST_IDLE;
      ST_PENDING: state_nxt = vs_fall ? ST_COMMIT : ST_PENDING;
      ST_COMMIT:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Walk from highest index down so the lowest-index hit is the last writer.
  always_comb begin
    hit_rgb = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (act_ctrl[i][3] &&
          pix_x >= act_x0[i] && pix_x < act_x1[i] &&
          pix_y >= act_y0[i] && pix_y < act_y1[i])
        hit_rgb = act_ctrl[i][2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      vs_prev <= 1'b1;
      r_out   <= 1'b0;
      g_out   <= 1'b0;
      b_out   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh_x0[i]    <= '0;
        sh_x1[i]    <= '0;
        sh_y0[i]    <= '0;
        sh_y1[i]    <= '0;
        sh_ctrl[i]  <= '0;
        act_x0[i]   <= '0;
        act_x1[i]   <= '0;
        act_y0[i]   <= '0;
        act_y1[i]   <= '0;
        act_ctrl[i] <= '0;
      end
    end else begin
      state   <= state_nxt;
      vs_prev <= v_sync;
      if (wr_fire) begin
        case (wr_field)
          3'd0:    sh_x0[wr_idx]   <= wr_data;
          3'd1:    sh_x1[wr_idx]   <= wr_data;
          3'd2:    sh_y0[wr_idx]   <= wr_data[8:0];
          3'd3:    sh_y1[wr_idx]   <= wr_data[8:0];
          3'd4:    sh_ctrl[wr_idx] <= wr_data[3:0];
          default: ;
        endcase
      end
      if (state == ST_COMMIT) begin
        for (int i = 0; i < 4; i++) begin
          act_x0[i]   <= sh_x0[i];
          act_x1[i]   <= sh_x1[i];
          act_y0[i]   <= sh_y0[i];
          act_y1[i]   <= sh_y1[i];
          act_ctrl[i] <= sh_ctrl[i];
        end
      end
      if (pix_clk) begin
        {r_out, g_out, b_out} <= hit_rgb;
      end
    end
  end

endmodule
